sparse_code_encoder: RTL and testbench

Inverse of the sparse symbol decoder. It accepts 8-bit one-hot-style symbols (8'h40, 8'h20, 8'h04) on a valid/ready input and emits the matching sparse 8-bit selection codes (8'h2a, 8'h1f, DEFAULT_CODE) on a registered valid/ready output. Illegal symbols are flagged and counted. An optional inter-token gap paces the downstream decoder so its combinational output can settle.

---
 rtl/sparse_code_pkg.sv | 17 +
 rtl/sparse_code_map.sv | 24 ++
 rtl/sparse_code_encoder.sv | 110 +++++++++++
 tb/tb_sparse_code_encoder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_code_pkg.sv
// Shared constants for the sparse code encoder/decoder pair.
// Both directions import this package, so the symbol and code values are defined only once.
package sparse_code_pkg;

    localparam logic [7:0] SYM_A  = 8'h40;
    localparam logic [7:0] SYM_B  = 8'h20;
    localparam logic [7:0] SYM_C  = 8'h04;
    localparam logic [7:0] CODE_A = 8'h2a;
    localparam logic [7:0] CODE_B = 8'h1f;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        GAP
    } state_t;

endpackage

// File: rtl/sparse_code_map.sv
// Combinational symbol-to-code map.
// Flags any symbol outside the three legal values as illegal.
module sparse_code_map
    import sparse_code_pkg::*;
#(
    parameter logic [7:0] DEFAULT_CODE = 8'h00
) (
    input  logic [7:0] i_sym,
    output logic [7:0] o_code,
    output logic       o_illegal
);

    always_comb begin
        o_code    = DEFAULT_CODE;
        o_illegal = 1'b0;
        case (i_sym)
            SYM_A:   o_code = CODE_A;
            SYM_B:   o_code = CODE_B;
            SYM_C:   o_code = DEFAULT_CODE;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sparse_code_encoder.sv
// Encodes one-hot-style symbols into sparse selection codes through a one-entry output register.
// An optional idle gap after each output transfer gives the downstream decoder time to settle.
//   state | meaning
//   EMPTY | no output held, ready for a symbol
//   FULL  | code held on the output until it is transferred
//   GAP   | forced idle cycles after a transfer (HOLD_CYCLES > 0)
module sparse_code_encoder
    import sparse_code_pkg::*;
#(
    parameter int         HOLD_CYCLES  = 0,
    parameter logic [7:0] DEFAULT_CODE = 8'h00,
    parameter int         ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_sym,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_code,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int              GAP_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(HOLD_CYCLES);
    localparam bit              NO_GAP   = (HOLD_CYCLES == 0);

    state_t               r_state;
    logic [GAP_W-1:0]     r_gap;
    logic                 r_valid;
    logic [7:0]           r_code;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [7:0] w_code;
    logic       w_illegal;
    logic       w_accept;
    logic       w_xfer;

    sparse_code_map #(
        .DEFAULT_CODE (DEFAULT_CODE)
    ) u_map (
        .i_sym     (in_sym),
        .o_code    (w_code),
        .o_illegal (w_illegal)
    );

    // With a gap configured, a new symbol may only enter from EMPTY.
    assign in_ready  = (r_state == EMPTY) || ((r_state == FULL) && out_ready && NO_GAP);
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = r_valid && out_ready;

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign out_err   = r_err;
    assign err_count = r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_gap     <= '0;
            r_valid   <= 1'b0;
            r_code    <= 8'h00;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_code <= w_code;
                r_err  <= w_illegal;
                if (w_illegal && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= FULL;
                        r_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (w_xfer && !w_accept) begin
                        r_valid <= 1'b0;
                        if (NO_GAP) begin
                            r_state <= EMPTY;
                        end else begin
                            r_state <= GAP;
                            r_gap   <= GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (r_gap <= GAP_W'(1)) begin
                        r_state <= EMPTY;
                        r_gap   <= '0;
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_code_encoder.sv
// Bench for sparse_code_encoder: three configurations (back-to-back, 3-cycle gap, 2-bit error counter)
// checked every cycle against a transaction-level model, plus directed literal expectations.
module tb_sparse_code_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [7:0] in_sym    [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [7:0] out_code  [3];
    logic       out_err   [3];
    logic [7:0] ec0;
    logic [7:0] ec1;
    logic [1:0] ec2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sparse_code_encoder #(.HOLD_CYCLES(0), .DEFAULT_CODE(8'h00), .ERR_CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sym(in_sym[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_code(out_code[0]), .out_err(out_err[0]),
        .err_count(ec0));

    sparse_code_encoder #(.HOLD_CYCLES(3), .DEFAULT_CODE(8'h00), .ERR_CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sym(in_sym[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_code(out_code[1]), .out_err(out_err[1]),
        .err_count(ec1));

    sparse_code_encoder #(.HOLD_CYCLES(0), .DEFAULT_CODE(8'h00), .ERR_CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_sym(in_sym[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_code(out_code[2]), .out_err(out_err[2]),
        .err_count(ec2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_ec(input int i);
        case (i)
            0:       return {24'h0, ec0};
            1:       return {24'h0, ec1};
            default: return {30'h0, ec2};
        endcase
    endfunction

    // Reference rules: the mapping table, its legality, and the downstream decoder
    function automatic logic [7:0] spec_code(input logic [7:0] s);
        if (s == 8'h40) return 8'h2a;
        if (s == 8'h20) return 8'h1f;
        return 8'h00;
    endfunction

    function automatic bit spec_illegal(input logic [7:0] s);
        return !(s == 8'h40 || s == 8'h20 || s == 8'h04);
    endfunction

    function automatic logic [7:0] dec(input logic [7:0] c);
        if (c == 8'h2a) return 8'h40;
        if (c == 8'h1f) return 8'h20;
        return 8'h04;
    endfunction

    // Model: a held output (if any), the idle cycles still owed, and the error tally
    int         HOLD [3] = '{0, 3, 0};
    int         CMAX [3] = '{255, 255, 3};
    bit         m_full [3];
    logic [7:0] m_code [3];
    bit         m_err  [3];
    int         m_gap  [3];
    int         m_cnt  [3];

    function automatic bit m_rdy(input int i);
        if (m_full[i]) return out_ready[i] && (HOLD[i] == 0);
        return m_gap[i] == 0;
    endfunction

    task automatic m_load(input int i);
        m_code[i] = spec_code(in_sym[i]);
        m_err[i]  = spec_illegal(in_sym[i]);
        if (m_err[i] && m_cnt[i] < CMAX[i]) m_cnt[i]++;
    endtask

    task automatic model_step(input int i);
        bit acc;
        acc = in_valid[i] && m_rdy(i);
        if (m_full[i]) begin
            if (out_ready[i]) begin
                if (acc) m_load(i);
                else begin
                    m_full[i] = 1'b0;
                    m_gap[i]  = HOLD[i];
                end
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
        end else if (acc) begin
            m_load(i);
            m_full[i] = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    m_full[i] = 1'b0;
                    m_gap[i]  = 0;
                    m_cnt[i]  = 0;
                end
                chk($sformatf("mdl_valid%0d", i), {31'h0, out_valid[i]}, {31'h0, m_full[i]});
                chk($sformatf("mdl_ready%0d", i), {31'h0, in_ready[i]}, {31'h0, m_rdy(i)});
                chk($sformatf("mdl_errcnt%0d", i), dut_ec(i), m_cnt[i]);
                if (m_full[i]) begin
                    chk($sformatf("mdl_code%0d", i), {24'h0, out_code[i]}, {24'h0, m_code[i]});
                    chk($sformatf("mdl_err%0d", i), {31'h0, out_err[i]}, {31'h0, m_err[i]});
                end
                if (rst_n) model_step(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nerr;
        int ngap;
        logic [7:0] s;
        logic [7:0] exp_sym;
        int exp_w2 [4] = '{1, 2, 3, 3};

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_sym[i]    = 8'h00;
            out_ready[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_valid", {31'h0, out_valid[0]}, 0);
        chk("rst_code", {24'h0, out_code[0]}, 0);
        chk("rst_err", {31'h0, out_err[0]}, 0);
        chk("rst_ready", {31'h0, in_ready[0]}, 1);
        chk("rst_errcnt", dut_ec(0), 0);

        // Stream of the three legal symbols at full throughput
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_sym[0]    = 8'h40;
        step();
        chk("t1_code0", {24'h0, out_code[0]}, 32'h2a);
        chk("t1_ready0", {31'h0, in_ready[0]}, 1);
        in_sym[0] = 8'h20;
        step();
        chk("t1_code1", {24'h0, out_code[0]}, 32'h1f);
        chk("t1_ready1", {31'h0, in_ready[0]}, 1);
        in_sym[0] = 8'h04;
        step();
        chk("t1_code2", {24'h0, out_code[0]}, 32'h00);
        chk("t1_err2", {31'h0, out_err[0]}, 0);
        chk("t1_errcnt", dut_ec(0), 0);
        in_valid[0] = 1'b0;
        step();
        chk("t1_drained", {31'h0, out_valid[0]}, 0);

        // Sweep of every symbol through encoder and decoder
        nerr = 0;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 256; k++) begin
            s = 8'(k);
            in_sym[0] = s;
            step();
            exp_sym = (s == 8'h40) ? 8'h40 : (s == 8'h20) ? 8'h20 : 8'h04;
            chk($sformatf("t2_dec_%02h", s), {24'h0, dec(out_code[0])}, {24'h0, exp_sym});
            if (out_err[0]) nerr++;
        end
        chk("t2_nerr", nerr, 253);
        chk("t2_errcnt", dut_ec(0), 32'hfd);
        in_sym[0] = 8'hff;
        repeat (4) step();
        chk("t2_errcnt_sat", dut_ec(0), 32'hff);
        in_valid[0] = 1'b0;
        step();

        // Backpressure holds the output stable
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_sym[0]    = 8'h40;
        step();
        in_valid[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t3_valid", {31'h0, out_valid[0]}, 1);
            chk("t3_code", {24'h0, out_code[0]}, 32'h2a);
            chk("t3_ready", {31'h0, in_ready[0]}, 0);
            step();
        end
        out_ready[0] = 1'b1;
        step();
        chk("t3_released", {31'h0, out_valid[0]}, 0);

        // Three idle cycles after each transfer
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_sym[1]    = 8'h40;
        chk("t4_ready_empty", {31'h0, in_ready[1]}, 1);
        step();
        chk("t4_code0", {24'h0, out_code[1]}, 32'h2a);
        chk("t4_ready_full", {31'h0, in_ready[1]}, 0);
        in_sym[1] = 8'h20;
        step();
        ngap = 0;
        for (int k = 0; k < 20; k++) begin
            if (in_ready[1]) break;
            if (!out_valid[1]) ngap++;
            step();
        end
        chk("t4_gap_len", ngap, 3);
        step();
        in_valid[1] = 1'b0;
        chk("t4_valid1", {31'h0, out_valid[1]}, 1);
        chk("t4_code1", {24'h0, out_code[1]}, 32'h1f);
        repeat (5) step();

        // Asynchronous reset while FULL
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_sym[0]    = 8'h20;
        step();
        in_valid[0] = 1'b0;
        chk("t5_pending", {24'h0, out_code[0]}, 32'h1f);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_full_valid", {31'h0, out_valid[0]}, 0);
        chk("t5_full_errcnt", dut_ec(0), 0);
        chk("t5_full_ready", {31'h0, in_ready[0]}, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Asynchronous reset mid-gap
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_sym[1]    = 8'h40;
        step();
        in_valid[1] = 1'b0;
        step();
        step();
        chk("t5_in_gap", {31'h0, in_ready[1]}, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_gap_valid", {31'h0, out_valid[1]}, 0);
        chk("t5_gap_ready", {31'h0, in_ready[1]}, 1);
        chk("t5_gap_errcnt", dut_ec(1), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_sym[0]    = 8'h20;
        step();
        in_valid[0] = 1'b0;
        chk("t5_after_valid", {31'h0, out_valid[0]}, 1);
        chk("t5_after_code", {24'h0, out_code[0]}, 32'h1f);
        step();

        // Two-bit counter saturates at 3
        out_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        in_sym[2]    = 8'hff;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t6_errcnt%0d", k), dut_ec(2), exp_w2[k]);
            chk($sformatf("t6_code%0d", k), {24'h0, out_code[2]}, 32'h00);
            chk($sformatf("t6_err%0d", k), {31'h0, out_err[2]}, 1);
        end
        in_valid[2] = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
